// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU with an optional iterative MUL/DIVU/REMU unit.
// Define MULDIV_EN to build the 32-iteration multiply/divide FSM; otherwise ops 9-11 return 0.
module execute_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] ST_value,
  input  logic [REGW-1:0]  dest,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             wb_en,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] st_out,
  output logic [REGW-1:0]  dest_out,
  output logic             mem_r_out,
  output logic             mem_w_out,
  output logic             wb_out
);

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       cmd,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic [4:0]              sh;
    sa = a;
    sh = b[4:0];
    case (cmd)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ~(a | b);
      4'd5:    return a ^ b;
      4'd6:    return a << sh;
      4'd7:    return a >> sh;
      4'd8:    return sa >>> sh;
`ifdef MULDIV_EN
      // Only reached with a zero divisor; nonzero divisors go through the FSM.
      4'd10:   return '1;
      4'd11:   return a;
`else
      4'd9, 4'd10, 4'd11: return '0;
`endif
      default: return a;
    endcase
  endfunction

  logic load_single;

`ifdef MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;
  localparam int         CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start, load_done;
  logic [3:0]       cmd_p1;
  logic [WIDTH-1:0] acc_p1, opa_p1, opb_p1, st_p1;
  logic [REGW-1:0]  dest_p1;
  logic             mr_p1, mw_p1, wb_p1;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             quo_bit;
  logic [WIDTH-1:0] rem_next, done_result;

  assign start = valid_in && ((EXE_CMD == OP_MUL) ||
                 (((EXE_CMD == OP_DIVU) || (EXE_CMD == OP_REMU)) && (val2 != '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (flush || state_q != BUSY) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = BUSY;
        BUSY:    if (cnt_q == LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall     = 1'b0;
    load_done = 1'b0;
    if (!reset && !flush) begin
      case (state_q)
        IDLE:    stall = start;
        BUSY:    stall = 1'b1;
        DONE:    load_done = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign load_single = !reset && !flush && (state_q == IDLE) && valid_in && !start;

  // Restoring division step: acc holds the partial remainder, opa shifts dividend out / quotient in.
  assign rem_sh      = {acc_p1, opa_p1[WIDTH-1]};
  assign rem_diff    = rem_sh - {1'b0, opb_p1};
  assign quo_bit     = ~rem_diff[WIDTH];
  assign rem_next    = quo_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign done_result = (cmd_p1 == OP_DIVU) ? opa_p1 : acc_p1;

  // Stage p1: latched operands and iterative datapath
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      cmd_p1  <= EXE_CMD;
      acc_p1  <= '0;
      opa_p1  <= val1;
      opb_p1  <= val2;
      st_p1   <= ST_value;
      dest_p1 <= dest;
      mr_p1   <= mem_r_en;
      mw_p1   <= mem_w_en;
      wb_p1   <= wb_en;
    end else if (state_q == BUSY) begin
      if (cmd_p1 == OP_MUL) begin
        if (opb_p1[0]) acc_p1 <= acc_p1 + opa_p1;
        opa_p1 <= opa_p1 << 1;
        opb_p1 <= opb_p1 >> 1;
      end else begin
        acc_p1 <= rem_next;
        opa_p1 <= {opa_p1[WIDTH-2:0], quo_bit};
      end
    end
  end
`else
  assign stall       = 1'b0;
  assign load_single = !reset && !flush && valid_in;
`endif

  // EX/MEM output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      st_out     <= '0;
      dest_out   <= '0;
      mem_r_out  <= 1'b0;
      mem_w_out  <= 1'b0;
      wb_out     <= 1'b0;
    end else if (load_single) begin
      out_valid  <= 1'b1;
      alu_result <= alu_single(EXE_CMD, val1, val2);
      st_out     <= ST_value;
      dest_out   <= dest;
      mem_r_out  <= mem_r_en;
      mem_w_out  <= mem_w_en;
      wb_out     <= wb_en;
`ifdef MULDIV_EN
    end else if (load_done) begin
      out_valid  <= 1'b1;
      alu_result <= done_result;
      st_out     <= st_p1;
      dest_out   <= dest_p1;
      mem_r_out  <= mr_p1;
      mem_w_out  <= mw_p1;
      wb_out     <= wb_p1;
`endif
    end else begin
      out_valid  <= 1'b0;
      mem_r_out  <= 1'b0;
      mem_w_out  <= 1'b0;
      wb_out     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: driver pushes expected results, a negedge monitor pops them.
// Expectations follow MULDIV_EN the same way the design does.
module tb_execute_stage;
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, valid_in, flush;
  logic [3:0]  EXE_CMD;
  logic [31:0] val1, val2, ST_value;
  logic [4:0]  dest;
  logic        mem_r_en, mem_w_en, wb_en;
  logic        stall, out_valid, mem_r_out, mem_w_out, wb_out;
  logic [31:0] alu_result, st_out;
  logic [4:0]  dest_out;

  execute_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .EXE_CMD(EXE_CMD),
    .val1(val1), .val2(val2), .ST_value(ST_value), .dest(dest),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .flush(flush),
    .stall(stall), .out_valid(out_valid), .alu_result(alu_result), .st_out(st_out),
    .dest_out(dest_out), .mem_r_out(mem_r_out), .mem_w_out(mem_w_out), .wb_out(wb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  d;
    logic        mr, mw, wb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return ~(a | b);
      4'd5:  return a ^ b;
      4'd6:  return a << b[4:0];
      4'd7:  return a >> b[4:0];
      4'd8:  return sa >>> b[4:0];
      4'd9:  return MD ? a * b : 32'd0;
      4'd10: return MD ? ((b == 0) ? 32'hFFFF_FFFF : a / b) : 32'd0;
      4'd11: return MD ? ((b == 0) ? a : a % b) : 32'd0;
      default: return a;
    endcase
  endfunction

  function automatic int exp_stalls(input logic [3:0] op, input logic [31:0] b);
    if (MD && (op == 4'd9 || ((op == 4'd10 || op == 4'd11) && b != 0))) return 33;
    return 0;
  endfunction

  // Present one instruction, hold it while stall is high, push its expected result on the consuming edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] st, input logic [4:0] d,
                       input logic mr, input logic mw, input logic wb);
    bit   done;
    int   stalls;
    exp_t e;
    done = 1'b0;
    stalls = 0;
    valid_in = 1'b1; EXE_CMD = op; val1 = a; val2 = b; ST_value = st; dest = d;
    mem_r_en = mr; mem_w_en = mw; wb_en = wb;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (stall) begin
        stalls++;
      end else begin
        e.res = ref_result(op, a, b); e.st = st; e.d = d; e.mr = mr; e.mw = mw; e.wb = wb;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) check("issue_timeout", 0, 1);
    else check("latency_out_valid", out_valid, 1);
    check("stall_cycles", stalls, exp_stalls(op, b));
    valid_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("alu_result", alu_result, mon_e.res);
          check("st_out", st_out, mon_e.st);
          check("dest_out", dest_out, mon_e.d);
          check("ctrl_out", {mem_r_out, mem_w_out, wb_out}, {mon_e.mr, mon_e.mw, mon_e.wb});
        end
      end else begin
        check("idle_ctrl", {mem_r_out, mem_w_out, wb_out}, 3'b000);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; EXE_CMD = 4'd0;
    val1 = '0; val2 = '0; ST_value = '0; dest = '0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_alu_result", alu_result, 0);
    check("reset_st_out", st_out, 0);
    check("reset_dest_out", dest_out, 0);
    check("reset_ctrl", {mem_r_out, mem_w_out, wb_out}, 3'b000);
    check("reset_stall", stall, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    issue(4'd0, 32'd7, 32'hFFFF_FFFD, 32'h0000_AAAA, 5'd3, 1'b0, 1'b0, 1'b1);
    check("add_7_m3", alu_result, 32'd4);
    issue(4'd8, 32'h8000_0000, 32'd4, 32'h1, 5'd4, 1'b1, 1'b0, 1'b1);
    check("sra", alu_result, 32'hF800_0000);
    issue(4'd1, 32'd0, 32'd1, 32'h2, 5'd5, 1'b0, 1'b1, 1'b0);
    check("sub_0_1", alu_result, 32'hFFFF_FFFF);
    issue(4'd9, 32'h0001_2345, 32'h10, 32'h1234, 5'd7, 1'b0, 1'b0, 1'b1);
    check("mul", alu_result, MD ? 32'h0012_3450 : 32'd0);
    check("mul_wb", wb_out, 1);
    @(negedge clk);
    check("mul_single_pulse", out_valid, 0);
    issue(4'd10, 32'd100, 32'd7, 32'h3, 5'd8, 1'b0, 1'b0, 1'b1);
    check("divu_100_7", alu_result, MD ? 32'd14 : 32'd0);
    issue(4'd11, 32'd100, 32'd7, 32'h4, 5'd9, 1'b0, 1'b0, 1'b1);
    check("remu_100_7", alu_result, MD ? 32'd2 : 32'd0);
    issue(4'd10, 32'd5, 32'd0, 32'h5, 5'd10, 1'b0, 1'b0, 1'b1);
    check("divu_by_zero", alu_result, MD ? 32'hFFFF_FFFF : 32'd0);
    issue(4'd11, 32'd5, 32'd0, 32'h6, 5'd11, 1'b0, 1'b0, 1'b1);
    check("remu_by_zero", alu_result, MD ? 32'd5 : 32'd0);

    // flush in the same cycle as an accept
    valid_in = 1'b1; EXE_CMD = 4'd9; val1 = 32'd3; val2 = 32'd5; wb_en = 1'b1; flush = 1'b1;
    #1 check("flush_accept_stall", stall, 0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0; valid_in = 1'b0; wb_en = 1'b0;
    #1 check("flush_accept_idle_stall", stall, 0);
    check("flush_accept_out_valid", out_valid, 0);

    // flush during BUSY cycle 10
    hold = MD ? 10 : 0;
    valid_in = 1'b1; EXE_CMD = 4'd9; val1 = 32'd11; val2 = 32'd13; wb_en = 1'b1;
    for (int i = 0; i < hold; i++) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    #1 check("flush_busy_stall", stall, 0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0; valid_in = 1'b0; wb_en = 1'b0;
    #1 check("flush_busy_next_stall", stall, 0);
    check("flush_busy_out_valid", out_valid, 0);
    repeat (40) @(negedge clk);

    // reset in the middle of a DIVU
    hold = MD ? 5 : 0;
    valid_in = 1'b1; EXE_CMD = 4'd10; val1 = 32'd100; val2 = 32'd7; ST_value = 32'h77;
    dest = 5'd12; mem_r_en = 1'b1; wb_en = 1'b1;
    for (int i = 0; i < hold; i++) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    #1 check("reset_mid_stall", stall, 0);
    @(posedge clk); @(negedge clk);
    check("reset_mid_out_valid", out_valid, 0);
    check("reset_mid_alu_result", alu_result, 0);
    check("reset_mid_st_out", st_out, 0);
    check("reset_mid_dest_out", dest_out, 0);
    check("reset_mid_ctrl", {mem_r_out, mem_w_out, wb_out}, 3'b000);
    reset = 1'b0; valid_in = 1'b0; mem_r_en = 1'b0; wb_en = 1'b0;
    issue(4'd0, 32'd20, 32'd22, 32'h9, 5'd13, 1'b0, 1'b0, 1'b1);
    check("add_after_reset", alu_result, 32'd42);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 40);
        default: b = $urandom;
      endcase
      issue(op, a, b, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width.
REQ-002 SHALL have parameter: REGW, 5, register-index width.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high.
REQ-005 SHALL have port: valid_in  in  1  the ID/EX register holds a live instruction.
REQ-006 SHALL have port: EXE_CMD  in  4  operation code.
REQ-007 SHALL have port: val1, val2, ST_value  in  WIDTH each  operands and store data from ID/EX.
REQ-008 SHALL have port: dest, mem_r_en, mem_w_en, wb_en  in  REGW/1/1/1  destination and control from ID/EX.
REQ-009 SHALL have port: flush  in  1  kill the in-flight instruction (taken branch).
REQ-010 SHALL have port: stall  out  1  hold ID/EX and earlier stages this cycle.
REQ-011 SHALL have port: out_valid, alu_result, st_out, dest_out, mem_r_out, mem_w_out, wb_out  out  1/WIDTH/WIDTH/REGW/1/1/1  registered EX/MEM fields.

Function
REQ-012 SHALL decode EXE_CMD as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 MUL, 10 DIVU, 11 REMU; 12-15 pass val1.
REQ-013 Shift amount SHALL be val2[4:0]; ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; MUL returns low WIDTH bits.
REQ-014 Single-cycle ops (0-8, 12-15) with valid_in=1 and FSM in IDLE SHALL load the output register at the next edge with out_valid=1; latency 1; stall=0.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 IDLE, valid_in=1, op MUL/DIVU/REMU, divisor nonzero: stall=1; operands latched; 5-bit counter=0; next state BUSY; out_valid=0 next edge.
REQ-017 BUSY SHALL run one shift-add (MUL) or restoring-division (DIVU/REMU) iteration per cycle with stall=1; after the 32nd iteration the next state is DONE.
REQ-018 DONE SHALL drive stall=0, load the result with the latched dest/control into the output register (out_valid=1 next edge), and return to IDLE without re-accepting the instruction.
REQ-019 Total: 33 stall cycles; out_valid rises 34 edges after first presentation.
REQ-020 DIVU/REMU with val2=0 SHALL be treated as single-cycle: DIVU yields all-ones, REMU yields val1.
REQ-021 Every cycle that does not load a valid result (valid_in=0, IDLE accept, BUSY) SHALL load out_valid=0 with mem_r_out, mem_w_out and wb_out forced 0.
REQ-022 flush=1 SHALL force IDLE, stall=0 and out_valid=0 at the next edge from any state; flush overrides an accept in the same cycle.
REQ-023 stall SHALL be combinational from state, valid_in, EXE_CMD, val2 and flush only.

Reset
REQ-024 reset=1 at an edge SHALL set state IDLE, counter 0, and clear out_valid, alu_result, st_out, dest_out, mem_r_out, mem_w_out and wb_out to 0.
REQ-025 reset SHALL abort an in-progress MUL/DIVU/REMU without producing a result; stall SHALL be 0 while reset=1.
REQ-026 reset SHALL take priority over flush and over all other inputs.

Configuration
REQ-027 Macro MULDIV_EN defined: SHALL implement MUL/DIVU/REMU per REQ-016..020.
REQ-028 MULDIV_EN undefined: SHALL remove the FSM and iterative datapath; opcodes 9-11 SHALL complete in one cycle with result 0; stall SHALL be tied to 0.

Verification
REQ-029 SHALL cover: after reset, ADD 7+(-3) -> next edge out_valid=1, alu_result=4, stall=0.
REQ-030 SHALL cover: SRA val1=0x80000000, val2=4 -> alu_result=0xF8000000; SUB 0-1 -> 0xFFFFFFFF.
REQ-031 SHALL cover: MUL 0x00012345*0x10 held under stall -> stall high exactly 33 cycles, one out_valid pulse with 0x00123450, wb_out matching input.
REQ-032 SHALL cover: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF in 1 cycle with no stall.
REQ-033 SHALL cover: flush at BUSY cycle 10 -> next edge stall=0, out_valid=0; no result ever emerges.
REQ-034 SHALL cover: reset asserted mid-DIVU -> all outputs 0 next edge; a following ADD completes normally in 1 cycle.
